// File: rtl/frame_cmd_gen.sv
// Frame command sequencer feeding the Ethernet packet builder's show-ahead command FIFO port.
// Sweeps frame size, optionally ramps the payload byte, and spaces commands with idle gaps.
module frame_cmd_gen #(
    parameter int CNT_WIDTH = 32,
    parameter int GAP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] cfg_num_frames,
    input  logic [10:0]          cfg_size_min,
    input  logic [10:0]          cfg_size_max,
    input  logic [10:0]          cfg_size_step,
    input  logic [GAP_WIDTH-1:0] cfg_gap,
    input  logic [47:0]          cfg_d_mac,
    input  logic [47:0]          cfg_s_mac,
    input  logic [15:0]          cfg_ethertype,
    input  logic [7:0]           cfg_payload,
    input  logic                 cfg_payload_inc,
    output logic                 cmd_valid,
    input  logic                 cmd_rd_en,
    output logic [10:0]          size,
    output logic [47:0]          d_mac,
    output logic [47:0]          s_mac,
    output logic [15:0]          ethertype,
    output logic [7:0]           payload,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] frames_issued
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [10:0] MIN_FRAME = 11'd14;

    logic [1:0]           state_reg,     state_next;
    logic [10:0]          size_reg,      size_next;
    logic [7:0]           payload_reg,   payload_next;
    logic [47:0]          d_mac_reg,     d_mac_next;
    logic [47:0]          s_mac_reg,     s_mac_next;
    logic [15:0]          ethertype_reg, ethertype_next;
    logic [CNT_WIDTH-1:0] frames_reg,    frames_next;
    logic                 done_reg,      done_next;
    logic [GAP_WIDTH-1:0] gap_cnt_reg,   gap_cnt_next;

    // Configuration captured at start; cfg_* inputs are not looked at again while busy.
    logic [CNT_WIDTH-1:0] num_reg,       num_next;
    logic [10:0]          size_lo_reg,   size_lo_next;
    logic [10:0]          size_hi_reg,   size_hi_next;
    logic [10:0]          step_reg,      step_next;
    logic [GAP_WIDTH-1:0] gap_reg,       gap_next;
    logic                 inc_reg,       inc_next;

    logic [10:0]          cfg_lo;
    logic [10:0]          cfg_hi;
    logic                 xfer;
    logic [11:0]          size_sum;
    logic [10:0]          size_wrap;
    logic [CNT_WIDTH-1:0] frames_inc;
    logic                 count_hit;

    assign cfg_lo = (cfg_size_min < MIN_FRAME) ? MIN_FRAME : cfg_size_min;
    assign cfg_hi = (cfg_size_max < cfg_lo) ? cfg_lo : cfg_size_max;

    assign xfer = (state_reg == ST_ISSUE) && cmd_rd_en;

    // 12-bit sum so an 11-bit overflow still counts as exceeding the upper bound.
    assign size_sum  = {1'b0, size_reg} + {1'b0, step_reg};
    assign size_wrap = (size_sum > {1'b0, size_hi_reg}) ? size_lo_reg : size_sum[10:0];

    assign frames_inc = frames_reg + 1'b1;
    assign count_hit  = (num_reg != '0) && (frames_inc == num_reg);

    always_comb begin
        state_next     = state_reg;
        size_next      = size_reg;
        payload_next   = payload_reg;
        d_mac_next     = d_mac_reg;
        s_mac_next     = s_mac_reg;
        ethertype_next = ethertype_reg;
        frames_next    = frames_reg;
        done_next      = 1'b0;
        gap_cnt_next   = gap_cnt_reg;
        num_next       = num_reg;
        size_lo_next   = size_lo_reg;
        size_hi_next   = size_hi_reg;
        step_next      = step_reg;
        gap_next       = gap_reg;
        inc_next       = inc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_ISSUE;
                    num_next       = cfg_num_frames;
                    size_lo_next   = cfg_lo;
                    size_hi_next   = cfg_hi;
                    step_next      = cfg_size_step;
                    gap_next       = cfg_gap;
                    inc_next       = cfg_payload_inc;
                    size_next      = cfg_lo;
                    payload_next   = cfg_payload;
                    d_mac_next     = cfg_d_mac;
                    s_mac_next     = cfg_s_mac;
                    ethertype_next = cfg_ethertype;
                    frames_next    = '0;
                end
            end

            ST_ISSUE: begin
                if (xfer) begin
                    frames_next = frames_inc;
                    size_next   = size_wrap;
                    if (inc_reg) begin
                        payload_next = payload_reg + 8'd1;
                    end
                    if (count_hit || stop) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (gap_reg != '0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = gap_reg;
                    end
                end else if (stop) begin
                    // Pending command is abandoned without being counted.
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end

            ST_GAP: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                    state_next = ST_ISSUE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            size_reg      <= '0;
            payload_reg   <= '0;
            d_mac_reg     <= '0;
            s_mac_reg     <= '0;
            ethertype_reg <= '0;
            frames_reg    <= '0;
            done_reg      <= 1'b0;
            gap_cnt_reg   <= '0;
            num_reg       <= '0;
            size_lo_reg   <= '0;
            size_hi_reg   <= '0;
            step_reg      <= '0;
            gap_reg       <= '0;
            inc_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            size_reg      <= size_next;
            payload_reg   <= payload_next;
            d_mac_reg     <= d_mac_next;
            s_mac_reg     <= s_mac_next;
            ethertype_reg <= ethertype_next;
            frames_reg    <= frames_next;
            done_reg      <= done_next;
            gap_cnt_reg   <= gap_cnt_next;
            num_reg       <= num_next;
            size_lo_reg   <= size_lo_next;
            size_hi_reg   <= size_hi_next;
            step_reg      <= step_next;
            gap_reg       <= gap_next;
            inc_reg       <= inc_next;
        end
    end

    assign cmd_valid     = (state_reg == ST_ISSUE);
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign size          = size_reg;
    assign payload       = payload_reg;
    assign d_mac         = d_mac_reg;
    assign s_mac         = s_mac_reg;
    assign ethertype     = ethertype_reg;
    assign frames_issued = frames_reg;

endmodule

// File: doc/frame_cmd_gen.md
Name: frame_cmd_gen

Overview:
- Programmable command sequencer that sits directly upstream of the Ethernet packet builder.
- Drives the builder's FIFO-style command interface with frame commands: size, destination MAC, source MAC, ethertype and payload fill byte.
- Sweeps frame size over a configured range, optionally increments the payload byte, and inserts idle gaps between commands.
- Stops after a programmed frame count or on an explicit stop request.

Parameters:
- CNT_WIDTH, 32, width of the frame-count configuration and the issued-frame counter.
- GAP_WIDTH, 16, width of the inter-command gap counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; latches all cfg_* inputs and begins issuing; ignored while busy
- stop  in  1  level; requests termination while busy
- cfg_num_frames  in  CNT_WIDTH  frames to issue; 0 = run until stop
- cfg_size_min  in  11  first/minimum frame size in bytes
- cfg_size_max  in  11  maximum frame size in bytes
- cfg_size_step  in  11  size increment per command
- cfg_gap  in  GAP_WIDTH  idle cycles with cmd_valid low after each accepted command
- cfg_d_mac  in  48  destination MAC
- cfg_s_mac  in  48  source MAC
- cfg_ethertype  in  16  ethertype
- cfg_payload  in  8  initial payload fill byte
- cfg_payload_inc  in  1  1 = payload byte increments (mod 256) per accepted command
- cmd_valid  out  1  command available (show-ahead FIFO semantics)
- cmd_rd_en  in  1  consumer pop request
- size  out  11  command frame size
- d_mac  out  48  command destination MAC
- s_mac  out  48  command source MAC
- ethertype  out  16  command ethertype
- payload  out  8  command fill byte
- busy  out  1  high in ISSUE or GAP
- done  out  1  one-cycle pulse on termination
- frames_issued  out  CNT_WIDTH  commands accepted since last start

Behaviour:
- Reset: state IDLE. cmd_valid, busy, done, frames_issued, size, d_mac, s_mac, ethertype and payload are all 0.
- Handshake: a transfer occurs when cmd_valid && cmd_rd_en in the same cycle.
  - cmd_rd_en may be held high permanently by the consumer; cmd_rd_en without cmd_valid has no effect.
  - Command outputs are registered and stay stable while cmd_valid=1 and no transfer has occurred.
- Config latch at start:
  - size_lo = max(cfg_size_min, 14).
  - size_hi = max(cfg_size_max, size_lo).
  - Step value 0 means a constant size.
- States:
  - IDLE: cmd_valid=0, busy=0. On start, go to ISSUE with size=size_lo, payload=cfg_payload, frames_issued=0. cmd_valid rises the cycle after start (1-cycle latency).
  - ISSUE: cmd_valid=1, busy=1. On transfer:
    - frames_issued increments.
    - next size = size+step, computed in 12 bits; if the result > size_hi, it wraps to size_lo.
    - payload increments if cfg_payload_inc.
    - Then: if the count is reached (cfg_num_frames != 0 and new frames_issued == cfg_num_frames), go to IDLE and pulse done. Else if stop, go to IDLE and pulse done. Else if gap == 0, stay in ISSUE (back-to-back, cmd_valid stays 1). Else go to GAP, loading the counter with gap.
    - If stop is asserted with no transfer in the same cycle, go to IDLE and pulse done; the pending command is dropped and not counted.
  - GAP: cmd_valid=0, busy=1. The counter decrements each cycle; when it equals 1, go to ISSUE. This gives exactly gap cycles of cmd_valid=0. stop in GAP goes to IDLE and pulses done.
- done is high for exactly one cycle, the cycle after the terminating event. frames_issued holds its value in IDLE until the next start.
- start while busy is ignored; cfg_* changes while busy have no effect.
- Reset mid-operation returns immediately to the reset values; no done pulse.

Test Plan:
- cfg_num_frames=3, size_min=64, max=64, step=0, gap=0, cmd_rd_en held 1, start -> cmd_valid high 3 consecutive cycles starting 1 cycle after start, size=64 each; done pulse next cycle; frames_issued=3.
- size_min=60, max=200, step=64, num=5, gap=0 -> sizes 60, 124, 188, 60, 124.
- size_min=5, max=3, step=0, num=2 -> size clamped to 14 both commands.
- gap=4, num=2, cmd_rd_en=1 -> command, 4 cycles cmd_valid=0, command, done.
- cmd_rd_en held 0 for 10 cycles in ISSUE -> cmd_valid stays 1, outputs stable, frames_issued=0; cfg_payload=0xFF with inc=1, three transfers -> payload 0xFF, 0x00, 0x01.
- num=0, stop asserted in GAP after 7 commands -> IDLE, done pulse, frames_issued=7. stop coincident with a transfer -> that command is counted. rst mid-ISSUE -> all outputs 0 next cycle, no done.
